// File: rtl/reaction_sequencer.sv
// Reaction-timer trial sequencer: 1 ms tick divider, LFSR pre-GO delay, reaction/cheat/timeout outcome.
// Optional running average of the last four valid results: define REACTION_AVG_EN.
module reaction_sequencer #(
  parameter int          TICK_DIV     = 50000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [15:0] RAND_MASK    = 16'h07FF,
  parameter int          MAX_MS       = 9999
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        react,
  output logic        go_led,
  output logic        busy,
  output logic [13:0] time_ms,
  output logic        valid,
  output logic        cheat,
  output logic        timeout,
  output logic [13:0] avg_ms,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GO   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int          CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [13:0] MAX_T = 14'(MAX_MS);

  logic [1:0]       r_state;
  logic             r_start_q;
  logic [15:0]      r_lfsr;
  logic [CNT_W-1:0] r_div;
  logic [15:0]      r_delay;
  logic [13:0]      r_time;
  logic             r_go;
  logic             r_busy;
  logic             r_valid;
  logic             r_cheat;
  logic             r_timeout;

  logic             w_tick;
  logic             w_start_edge;
  logic             w_lfsr_fb;
  logic [15:0]      w_delay;

  assign w_tick       = (r_div == CNT_W'(TICK_DIV - 1));
  assign w_start_edge = start & ~r_start_q;
  assign w_lfsr_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_delay      = 16'(MIN_DELAY_MS) + (r_lfsr & RAND_MASK);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_lfsr    <= 16'hACE1;
      r_div     <= '0;
      r_delay   <= '0;
      r_time    <= '0;
      r_go      <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_cheat   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_start_q <= start;
      r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
      r_div     <= w_tick ? '0 : r_div + CNT_W'(1);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_edge) begin
            r_state   <= S_WAIT;
            r_busy    <= 1'b1;
            r_delay   <= w_delay;
            r_div     <= '0;
            r_time    <= '0;
            r_valid   <= 1'b0;
            r_cheat   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        S_WAIT: begin
          if (react) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_cheat <= 1'b1;
          end else if (w_tick) begin
            r_delay <= r_delay - 16'd1;
            // A zero delay (possible only with MIN_DELAY_MS = 0) leaves at the first tick.
            if (r_delay <= 16'd1) begin
              r_state <= S_GO;
              r_go    <= 1'b1;
              r_div   <= '0;
            end
          end
        end
        S_GO: begin
          if (react) begin
            r_state <= S_DONE;
            r_go    <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end else if (w_tick && (r_time != MAX_T)) begin
            r_time <= r_time + 14'd1;
            if (r_time == MAX_T - 14'd1) begin
              r_state   <= S_DONE;
              r_go      <= 1'b0;
              r_busy    <= 1'b0;
              r_timeout <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef REACTION_AVG_EN
  logic [3:0][13:0] r_hist;
  logic [13:0]      r_avg;
  logic [15:0]      w_sum;
  logic             w_push;

  // The value shifted in is the count held at the reacting edge, which is the final result.
  assign w_push = (r_state == S_GO) & react;
  assign w_sum  = 16'(r_hist[0]) + 16'(r_hist[1]) + 16'(r_hist[2]) + 16'(r_hist[3]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hist <= '0;
      r_avg  <= '0;
    end else begin
      if (w_push) begin
        r_hist <= {r_hist[2:0], r_time};
      end
      r_avg <= w_sum[15:2];
    end
  end

  assign avg_ms = r_avg;
`else
  assign avg_ms = '0;
`endif

  assign go_led    = r_go;
  assign busy      = r_busy;
  assign time_ms   = r_time;
  assign valid     = r_valid;
  assign cheat     = r_cheat;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Directed bench for reaction_sequencer: cycle-level outcome model plus hand-computed expectations.
// Build with REACTION_AVG_EN defined to also exercise the running average.
module tb_reaction_sequencer;

  localparam int TD    = 4;
  localparam int MIN_D = 3;
  localparam int MASK  = 3;
  localparam int MAXT  = 20;

  logic        CLK;
  logic        RST;
  logic        start;
  logic        react;
  logic        go_led;
  logic        busy;
  logic [13:0] time_ms;
  logic        valid;
  logic        cheat;
  logic        timeout;
  logic [13:0] avg_ms;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;
  bit chk_en;

  reaction_sequencer #(
    .TICK_DIV(TD), .MIN_DELAY_MS(MIN_D), .RAND_MASK(16'h0003), .MAX_MS(MAXT)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .react(react),
    .go_led(go_led), .busy(busy), .time_ms(time_ms), .valid(valid),
    .cheat(cheat), .timeout(timeout), .avg_ms(avg_ms), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_WAIT, M_GO, M_DONE} m_state_t;

  m_state_t    m_state;
  logic [15:0] m_lfsr;
  bit          m_start_q;
  int          m_n;
  int          m_wait;
  int          m_last_d;
  int          m_time;
  bit          m_valid;
  bit          m_cheat;
  bit          m_timeout;
  int          m_avg;
  int          m_hist[4];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_state = M_IDLE; m_lfsr = 16'hACE1; m_start_q = 0;
      m_n = 0; m_wait = 0; m_time = 0;
      m_valid = 0; m_cheat = 0; m_timeout = 0; m_avg = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
    end else begin
`ifdef REACTION_AVG_EN
      m_avg = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
`else
      m_avg = 0;
`endif
      case (m_state)
        M_IDLE, M_DONE: begin
          if (start && !m_start_q) begin
            m_last_d = MIN_D + int'(m_lfsr & 16'(MASK));
            m_wait   = m_last_d * TD;
            m_state  = M_WAIT; m_n = 0; m_time = 0;
            m_valid  = 0; m_cheat = 0; m_timeout = 0;
          end
        end
        M_WAIT: begin
          m_n++;
          if (react) begin m_state = M_DONE; m_cheat = 1; end
          else if (m_n == m_wait) begin m_state = M_GO; m_n = 0; end
        end
        M_GO: begin
          m_n++;
          if (react) begin
            m_state = M_DONE; m_valid = 1; m_time = (m_n - 1) / TD;
            m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = m_time;
          end else begin
            m_time = m_n / TD;
            if (m_time >= MAXT) begin m_time = MAXT; m_state = M_DONE; m_timeout = 1; end
          end
        end
        default: m_state = M_IDLE;
      endcase
      m_start_q = start;
      m_lfsr    = lfsr_step(m_lfsr);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    logic [32:0] exp_v;
    logic [32:0] act_v;
    if (chk_en) begin
      exp_v = {m_state == M_GO, m_state == M_WAIT || m_state == M_GO, 14'(m_time),
               m_valid, m_cheat, m_timeout, 14'(m_avg)};
      act_v = {go_led, busy, time_ms, valid, cheat, timeout, avg_ms};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL outputs @%0t: got go=%b busy=%b t=%0d v=%b c=%b to=%b avg=%0d expected go=%b busy=%b t=%0d v=%b c=%b to=%b avg=%0d",
                 $time, go_led, busy, time_ms, valid, cheat, timeout, avg_ms,
                 exp_v[32], exp_v[31], exp_v[30:17], exp_v[16], exp_v[15], exp_v[14], exp_v[13:0]);
      end
    end
  end

  // ---------------- driver tasks / literal checks ----------------
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start_wait_go(input string name);
    int cyc;
    cyc = -1;
    @(negedge CLK) start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        check({name, "_busy_at_e0"}, int'(busy), 1);
        start = 1'b0;
      end
      if (go_led) begin cyc = k - 1; break; end
    end
    check({name, "_go_delay"}, cyc, m_last_d * TD);
  endtask

  task automatic react_after(input int off);
    repeat (off - 1) @(negedge CLK);
    react = 1'b1;
    @(negedge CLK) react = 1'b0;
  endtask

  int exp_avg[4];
  int react_off[4];
  int exp_t[4];

  initial begin
    int cyc;
    bit go_seen;
    n_vec = 0; n_err = 0; chk_en = 0;
    RST = 1'b1; start = 1'b1; react = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_en = 1;
    check("reset_time", int'(time_ms), 0);
    check("reset_flags", int'({go_led, busy, valid, cheat, timeout}), 0);

    // start held through reset: edge on first cycle, LFSR ACE1 -> D = 3 + 1 = 4 -> 16 cycles
    RST = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK);
      if (k == 1) begin check("t1_busy_at_e0", int'(busy), 1); start = 1'b0; end
      if (go_led) begin cyc = k - 1; break; end
    end
    check("t1_go_delay_literal", cyc, 16);

    react_after(37);
    check("t1_valid", int'(valid), 1);
    check("t1_time", int'(time_ms), 9);
    check("t1_go_busy", int'({go_led, busy}), 0);
    repeat (10) @(negedge CLK);
    check("t1_hold_valid", int'({valid, cheat, timeout}), 3'b100);
    check("t1_hold_time", int'(time_ms), 9);

    // react during WAIT
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    repeat (2) @(negedge CLK);
    react = 1'b1;
    @(negedge CLK) react = 1'b0;
    check("cheat_flags", int'({valid, cheat, timeout}), 3'b010);
    check("cheat_time", int'(time_ms), 0);
    go_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (go_led) go_seen = 1;
    end
    check("cheat_no_go", int'(go_seen), 0);

    // no react: timeout 80 cycles after GO entry
    pulse_start_wait_go("to");
    cyc = -1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge CLK);
      if (timeout) begin cyc = k; break; end
    end
    check("to_cycles", cyc, 80);
    check("to_time", int'(time_ms), 20);
    repeat (20) @(negedge CLK);
    check("to_no_wrap", int'(time_ms), 20);
    check("to_flags", int'({valid, cheat, timeout}), 3'b001);

    // react on the edge that would take time_ms from 5 to 6
    pulse_start_wait_go("coin");
    react_after(24);
    check("coin_time", int'(time_ms), 5);
    check("coin_valid", int'(valid), 1);

    // RST mid-GO
    pulse_start_wait_go("rst");
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_outputs", int'({go_led, busy, valid, cheat, timeout}), 0);
    check("rst_time", int'(time_ms), 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // running average: results 8, 12, 4, 16
    react_off = '{33, 49, 17, 65};
    exp_t     = '{8, 12, 4, 16};
`ifdef REACTION_AVG_EN
    exp_avg = '{2, 5, 6, 10};
`else
    exp_avg = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      pulse_start_wait_go("avg");
      react_after(react_off[i]);
      check("avg_result_time", int'(time_ms), exp_t[i]);
      repeat (2) @(negedge CLK);
      check("avg_value", int'(avg_ms), exp_avg[i]);
    end
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    @(negedge CLK) react = 1'b1;
    @(negedge CLK) react = 1'b0;
    repeat (3) @(negedge CLK);
    check("avg_cheat_flag", int'(cheat), 1);
    check("avg_after_cheat", int'(avg_ms), exp_avg[3]);

    repeat (5) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
